// File: rtl/gcd_pkg.sv
//------------------------------------------------------------------------------
// Module  : gcd_pkg
// Brief   : Shared state encoding, branch-select encoding and default widths
//           for the iterative GCD engine.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package gcd_pkg;

    localparam int c_w_default  = 16;
    localparam int c_cw_default = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_LOAD = 2'd0,
        SEL_SWAP = 2'd1,
        SEL_SUB  = 2'd2,
        SEL_HOLD = 2'd3
    } sel_t;

endpackage : gcd_pkg

`default_nettype wire

// File: rtl/gcd_unit_iter_datapath.sv
//------------------------------------------------------------------------------
// Module  : gcd_unit_iter_datapath
// Brief   : A/B operand registers, swap/subtract muxing, result register and
//           status flags. Optional saturating step counter (GCD_ITER_COUNT_EN).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcd_unit_iter_datapath
    import gcd_pkg::*;
#(
    parameter int W  = c_w_default
`ifdef GCD_ITER_COUNT_EN
   ,parameter int CW = c_cw_default
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  sel_t          i_sel,
    input  logic          i_latch_result,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    output logic          o_a_lt_b,
    output logic          o_b_zero,
    output logic [W-1:0]  o_result
`ifdef GCD_ITER_COUNT_EN
   ,output logic [CW-1:0] o_iter
`endif
);

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;

    assign o_a_lt_b = (r_a < r_b);
    assign o_b_zero = (r_b == '0);
    assign o_result = r_result;

    // Operand inputs reach the registers only through SEL_LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            case (i_sel)
                SEL_LOAD: begin
                    r_a <= i_a;
                    r_b <= i_b;
                end
                SEL_SWAP: begin
                    r_a <= r_b;
                    r_b <= r_a;
                end
                SEL_SUB:  r_a <= r_a - r_b;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (i_latch_result) begin
            r_result <= r_a;
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [CW-1:0] r_iter;
    logic [CW-1:0] r_iter_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter <= '0;
        end else if (i_sel == SEL_LOAD) begin
            r_iter <= '0;
        end else if ((i_sel == SEL_SWAP || i_sel == SEL_SUB) && (r_iter != '1)) begin
            r_iter <= r_iter + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter_out <= '0;
        end else if (i_latch_result) begin
            r_iter_out <= r_iter;
        end
    end

    assign o_iter = r_iter_out;
`endif

endmodule : gcd_unit_iter_datapath

`default_nettype wire

// File: rtl/gcd_unit_iter.sv
//------------------------------------------------------------------------------
// Module  : gcd_unit_iter
// Brief   : Multi-cycle subtractive-Euclid GCD with valid/ready handshakes.
//           Optional step-count output enabled by macro GCD_ITER_COUNT_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcd_unit_iter
    import gcd_pkg::*;
#(
    parameter int W  = c_w_default,
    parameter int CW = c_cw_default
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  operands_bits_A,
    input  logic [W-1:0]  operands_bits_B,
    input  logic          operands_val,
    output logic          operands_rdy,
    output logic [W-1:0]  result_bits_data,
    output logic          result_val,
    input  logic          result_rdy
`ifdef GCD_ITER_COUNT_EN
   ,output logic [CW-1:0] result_bits_iter
`endif
);

    if (W < 2 || CW < 1) begin : g_param_check
        $error("gcd_unit_iter: W must be >= 2 and CW >= 1");
    end

    state_t r_state;
    state_t w_state_nxt;
    sel_t   w_sel;
    logic   w_latch_result;
    logic   w_a_lt_b;
    logic   w_b_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel          = SEL_HOLD;
        w_latch_result = 1'b0;
        case (r_state)
            IDLE: begin
                if (operands_val) begin
                    w_sel       = SEL_LOAD;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_a_lt_b) begin
                    w_sel = SEL_SWAP;
                end else if (!w_b_zero) begin
                    w_sel = SEL_SUB;
                end else begin
                    w_latch_result = 1'b1;
                    w_state_nxt    = DONE;
                end
            end
            DONE: begin
                if (result_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only.
    assign operands_rdy = (r_state == IDLE);
    assign result_val   = (r_state == DONE);

    gcd_unit_iter_datapath #(
        .W  (W)
`ifdef GCD_ITER_COUNT_EN
       ,.CW (CW)
`endif
    ) u_datapath (
        .clk            (clk),
        .rst            (reset),
        .i_sel          (w_sel),
        .i_latch_result (w_latch_result),
        .i_a            (operands_bits_A),
        .i_b            (operands_bits_B),
        .o_a_lt_b       (w_a_lt_b),
        .o_b_zero       (w_b_zero),
        .o_result       (result_bits_data)
`ifdef GCD_ITER_COUNT_EN
       ,.o_iter         (result_bits_iter)
`endif
    );

endmodule : gcd_unit_iter

`default_nettype wire

// File: tb/tb_gcd_unit_iter.sv
//------------------------------------------------------------------------------
// Module  : tb_gcd_unit_iter
// Brief   : Self-checking bench for gcd_unit_iter (16-bit and 4-bit instances).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gcd_unit_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] op_a, op_b;
    logic        op_val;
    logic        op_rdy;
    logic [15:0] res_data;
    logic        res_val;
    logic        res_rdy;

    logic [3:0]  op_a4, op_b4;
    logic        op_val4;
    logic        op_rdy4;
    logic [3:0]  res_data4;
    logic        res_val4;
    logic        res_rdy4;

`ifdef GCD_ITER_COUNT_EN
    logic [16:0] res_iter;
    logic [2:0]  res_iter4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gcd_unit_iter #(.W(16), .CW(17)) dut (
        .clk              (clk),
        .reset            (reset),
        .operands_bits_A  (op_a),
        .operands_bits_B  (op_b),
        .operands_val     (op_val),
        .operands_rdy     (op_rdy),
        .result_bits_data (res_data),
        .result_val       (res_val),
        .result_rdy       (res_rdy)
`ifdef GCD_ITER_COUNT_EN
       ,.result_bits_iter (res_iter)
`endif
    );

    gcd_unit_iter #(.W(4), .CW(3)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .operands_bits_A  (op_a4),
        .operands_bits_B  (op_b4),
        .operands_val     (op_val4),
        .operands_rdy     (op_rdy4),
        .result_bits_data (res_data4),
        .result_val       (res_val4),
        .result_rdy       (res_rdy4)
`ifdef GCD_ITER_COUNT_EN
       ,.result_bits_iter (res_iter4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Accept one operand pair, time the result, check it, then release it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int exp_d, input int exp_lat, input int exp_it);
        int lat = 0;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(op_rdy), 32'd1);
        op_a = a; op_b = b; op_val = 1'b1;
        @(posedge clk); #1;
        op_val = 1'b0;
        do begin
            if (!res_val) begin
                @(posedge clk); #1;
                lat++;
            end
        end while (!res_val && lat < 400);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, 32'(res_data), 32'(exp_d));
`ifdef GCD_ITER_COUNT_EN
        chk({tag, "_iter"}, 32'(res_iter), 32'(exp_it));
`else
        if (exp_it < 0) $display("bad iter expectation for %s", tag);
`endif
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        chk({tag, "_idle"}, 32'(op_rdy), 32'd1);
    endtask

    initial begin
        int bad;
        int lat;
        int sent, recv, cyc;
        int unsigned exp_q[$];
        logic [7:0] ra, rb;
        logic fire_in, fire_out;

        reset = 1'b1; op_val = 1'b0; op_a = '0; op_b = '0; res_rdy = 1'b0;
        op_val4 = 1'b0; op_a4 = '0; op_b4 = '0; res_rdy4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rdy", 32'(op_rdy), 32'd1);
        chk("rst_val", 32'(res_val), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);

        res_rdy = 1'b1;
        run_op("g27_15", 16'd27, 16'd15, 3, 10, 9);
        run_op("g0_0",   16'd0,  16'd0,  0, 1, 0);
        run_op("g0_7",   16'd0,  16'd7,  7, 2, 1);
        run_op("g7_0",   16'd7,  16'd0,  7, 1, 0);
        run_op("g5_5",   16'd5,  16'd5,  5, 3, 2);

        // Result held while the consumer stalls.
        @(negedge clk);
        op_a = 16'd12; op_b = 16'd18; op_val = 1'b1;
        @(posedge clk); #1;
        op_val = 1'b0;
        lat = 0;
        while (!res_val && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_lat", 32'(lat), 32'd7);
        bad = 0;
        op_val = 1'b1; op_a = 16'd99; op_b = 16'd33;
        for (int i = 0; i < 20; i++) begin
            if (res_data !== 16'd6 || op_rdy !== 1'b0 || res_val !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        op_val = 1'b0;
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        chk("hold_idle_rdy", 32'(op_rdy), 32'd1);
        chk("hold_idle_val", 32'(res_val), 32'd0);
        op_a = 16'd9; op_b = 16'd3; op_val = 1'b1;
        @(posedge clk); #1;
        op_val = 1'b0;
        chk("hold_reaccept", 32'(op_rdy), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_reaccept_data", 32'(res_data), 32'd3);
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;

        // Reset in the middle of a long computation.
        @(negedge clk);
        op_a = 16'd1000; op_b = 16'd3; op_val = 1'b1;
        @(posedge clk); #1;
        op_val = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_rdy", 32'(op_rdy), 32'd1);
        chk("midrst_val", 32'(res_val), 32'd0);
        chk("midrst_data", 32'(res_data), 32'd0);
        run_op("g9_6", 16'd9, 16'd6, 3, 6, 5);

        // 4-bit instance: all-ones against one, counter saturates at 7.
        @(negedge clk);
        op_a4 = 4'd15; op_b4 = 4'd1; op_val4 = 1'b1;
        @(posedge clk); #1;
        op_val4 = 1'b0;
        lat = 0;
        while (!res_val4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w4_lat", 32'(lat), 32'd17);
        chk("w4_data", 32'(res_data4), 32'd1);
`ifdef GCD_ITER_COUNT_EN
        chk("w4_iter_sat", 32'(res_iter4), 32'd7);
`endif
        res_rdy4 = 1'b1;
        @(posedge clk); #1;
        res_rdy4 = 1'b0;

        // Random 8-bit stream under random valid/ready stalls.
        sent = 0; recv = 0; cyc = 0;
        while (recv < 500 && cyc < 60000) begin
            @(negedge clk);
            if (!(op_val && !op_rdy)) begin
                if (sent < 500 && ($urandom_range(0, 3) != 0)) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    op_a = {8'd0, ra}; op_b = {8'd0, rb}; op_val = 1'b1;
                end else begin
                    op_val = 1'b0;
                    op_a = 16'($urandom); op_b = 16'($urandom);
                end
            end
            res_rdy = ($urandom_range(0, 2) != 0);
            #1;
            fire_in  = op_val && op_rdy;
            fire_out = res_val && res_rdy;
            if (fire_in) begin
                exp_q.push_back(ref_gcd(32'(op_a), 32'(op_b)));
                sent++;
            end
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", 32'(res_data), 32'hFFFF_FFFF);
                end else begin
                    chk("stream_data", 32'(res_data), exp_q.pop_front());
                end
                recv++;
            end
            @(posedge clk);
            #1;
            if (fire_in) op_val = 1'b0;
            cyc++;
        end
        op_val = 1'b0;
        res_rdy = 1'b0;
        chk("stream_recv", 32'(recv), 32'd500);
        chk("stream_sent", 32'(sent), 32'd500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gcd_unit_iter

`default_nettype wire
